// File: rtl/trap_ctrl_if.sv
// Bundle of the trap controller's pipeline-side and CSR-side signals.
// The master is the pipeline/CSR unit; the slave is trap_ctrl itself.
interface trap_ctrl_if #(
    parameter int N = 64
);
    logic         exceptValid;
    logic [6:0]   exceptSignal;
    logic [N-1:0] exceptPc;
    logic [N-1:0] exceptAddr;
    logic         mret;
    logic         csrWe;
    logic [1:0]   csrSel;
    logic [N-1:0] csrWdata;
    logic         flush;
    logic         redirect;
    logic [N-1:0] redirectPc;
    logic         busy;
    logic [N-1:0] mepc;
    logic [N-1:0] mcause;
    logic [N-1:0] mtval;
    logic [N-1:0] mtvec;

    modport master (
        output exceptValid, exceptSignal, exceptPc, exceptAddr, mret,
               csrWe, csrSel, csrWdata,
        input  flush, redirect, redirectPc, busy, mepc, mcause, mtval, mtvec
    );

    modport slave (
        input  exceptValid, exceptSignal, exceptPc, exceptAddr, mret,
               csrWe, csrSel, csrWdata,
        output flush, redirect, redirectPc, busy, mepc, mcause, mtval, mtvec
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises E-stage exceptions, latches mepc/mcause/mtval,
// then sequences flush -> redirect to mtvec (trap) or to mepc (mret).
module trap_ctrl #(
    parameter int           N           = 64,
    parameter logic [N-1:0] MTVEC_RESET = '0
) (
    input  logic        clk,
    input  logic        reset,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    localparam logic [1:0] SEL_MTVEC  = 2'd0;
    localparam logic [1:0] SEL_MEPC   = 2'd1;
    localparam logic [1:0] SEL_MCAUSE = 2'd2;
    localparam logic [1:0] SEL_MTVAL  = 2'd3;

    state_t       state_q, state_d;
    logic         tgt_mtvec_q, tgt_mtvec_d;
    logic [N-1:0] target_q, target_d;
    logic [N-1:0] redirect_pc_q, redirect_pc_d;
    logic [N-1:0] mepc_q, mepc_d;
    logic [N-1:0] mcause_q, mcause_d;
    logic [N-1:0] mtval_q, mtval_d;
    logic [N-1:0] mtvec_q, mtvec_d;

    logic         trap;
    logic [N-1:0] cause;

    assign trap = bus.exceptValid & (|bus.exceptSignal);

    // Fixed priority: breakpoint, then misaligned, then page faults, then access faults.
    always_comb begin
        cause = '0;
        if      (bus.exceptSignal[6]) cause = N'(3);
        else if (bus.exceptSignal[0]) cause = N'(4);
        else if (bus.exceptSignal[2]) cause = N'(6);
        else if (bus.exceptSignal[4]) cause = N'(13);
        else if (bus.exceptSignal[5]) cause = N'(15);
        else if (bus.exceptSignal[1]) cause = N'(5);
        else if (bus.exceptSignal[3]) cause = N'(7);
    end

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        tgt_mtvec_d   = tgt_mtvec_q;
        target_d      = target_q;
        redirect_pc_d = redirect_pc_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mtvec_d       = mtvec_q;

        if (bus.csrWe) begin
            case (bus.csrSel)
                SEL_MTVEC:  mtvec_d  = {bus.csrWdata[N-1:2], 2'b00};
                SEL_MEPC:   mepc_d   = {bus.csrWdata[N-1:1], 1'b0};
                SEL_MCAUSE: mcause_d = bus.csrWdata;
                SEL_MTVAL:  mtval_d  = bus.csrWdata;
                default:    ;
            endcase
        end

        case (state_q)
            IDLE: begin
                // Trap latch overrides a same-edge CSR write to mepc/mcause/mtval.
                if (trap) begin
                    mepc_d      = {bus.exceptPc[N-1:1], 1'b0};
                    mcause_d    = cause;
                    mtval_d     = bus.exceptSignal[6] ? bus.exceptPc : bus.exceptAddr;
                    tgt_mtvec_d = 1'b1;
                    state_d     = FLUSH;
                end else if (bus.exceptValid && bus.mret) begin
                    target_d    = mepc_q;
                    tgt_mtvec_d = 1'b0;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                redirect_pc_d = tgt_mtvec_q ? mtvec_q : target_q;
                state_d       = REDIRECT;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            tgt_mtvec_q   <= 1'b0;
            target_q      <= '0;
            redirect_pc_q <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mtvec_q       <= {MTVEC_RESET[N-1:2], 2'b00};
        end else begin
            state_q       <= state_d;
            tgt_mtvec_q   <= tgt_mtvec_d;
            target_q      <= target_d;
            redirect_pc_q <= redirect_pc_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mtvec_q       <= mtvec_d;
        end
    end

    assign bus.flush      = (state_q == FLUSH);
    assign bus.redirect   = (state_q == REDIRECT);
    assign bus.busy       = (state_q != IDLE);
    assign bus.redirectPc = redirect_pc_q;
    assign bus.mepc       = mepc_q;
    assign bus.mcause     = mcause_q;
    assign bus.mtval      = mtval_q;
    assign bus.mtvec      = mtvec_q;
endmodule
